// File: rtl/platform_pkg.sv
// Platform-wide bus definitions: decoder FSM states, default slave address map and slave indices.
package platform_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } wb_dec_state_e;

  localparam int unsigned SLV_DMEM       = 0;
  localparam int unsigned SLV_MTIMER     = 1;
  localparam int unsigned SLV_LED_DRIVER = 2;
  localparam int unsigned SLV_RESERVED   = 3;

  // Index 0 in the low ADDR_W bits: {reserved, LED, mtimer, DMEM}
  localparam logic [4*32-1:0] SLAVE_BASE_DEFAULT = {
    32'hA000_0000, 32'h9000_1000, 32'h9000_0000, 32'h8000_0000
  };
  localparam logic [4*32-1:0] SLAVE_MASK_DEFAULT = {
    32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000
  };

  // Index width that stays legal for a single-slave build
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/wb_addr_decoder_if.sv
// Wishbone decoder boundary: core-facing request/response plus per-slave strobes and responses.
interface wb_addr_decoder_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
);
  localparam int unsigned SEL_W = DATA_W / 8;

  logic                         m_cyc_i;
  logic                         m_stb_i;
  logic                         m_we_i;
  logic [ADDR_W-1:0]            m_adr_i;
  logic [DATA_W-1:0]            m_dat_i;
  logic [SEL_W-1:0]             m_sel_i;
  logic [DATA_W-1:0]            m_dat_o;
  logic                         m_ack_o;
  logic                         m_err_o;
  logic                         m_stall_o;

  logic [NUM_SLAVES-1:0]        s_cyc_o;
  logic [NUM_SLAVES-1:0]        s_stb_o;
  logic                         s_we_o;
  logic [ADDR_W-1:0]            s_adr_o;
  logic [DATA_W-1:0]            s_dat_o;
  logic [SEL_W-1:0]             s_sel_o;
  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0]        s_ack_i;
  logic [NUM_SLAVES-1:0]        s_err_i;
  logic [NUM_SLAVES-1:0]        s_stall_i;

  // Decoder view: slave to the core, master to the peripherals
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_dat_o, m_ack_o, m_err_o, m_stall_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i, s_err_i, s_stall_i
  );

  // Environment view: the core plus the peripherals around the decoder
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_dat_o, m_ack_o, m_err_o, m_stall_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i, s_err_i, s_stall_i
  );

endinterface

// File: rtl/wb_addr_match.sv
// Combinational NUM_SLAVES-way base/mask match; the lowest matching index wins.
module wb_addr_match #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IDX_W      = 2
) (
  input  logic [ADDR_W-1:0]            adr,
  input  logic [NUM_SLAVES*ADDR_W-1:0] base,
  input  logic [NUM_SLAVES*ADDR_W-1:0] mask,
  output logic                         hit_c,
  output logic [IDX_W-1:0]             idx_c
);

  // Scan from the top so the lowest hit is the one left standing
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int k = int'(NUM_SLAVES) - 1; k >= 0; k--) begin
      if ((adr & mask[k*ADDR_W +: ADDR_W]) == base[k*ADDR_W +: ADDR_W]) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_addr_decoder.sv
// 1-to-N pipelined Wishbone decoder with single outstanding transaction and error on unmapped access.
// Define WB_DECODER_TIMEOUT_EN to add the bus-timeout watchdog.
module wb_addr_decoder
  import platform_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES     = 4,
  parameter int unsigned                  ADDR_W         = 32,
  parameter int unsigned                  DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = SLAVE_BASE_DEFAULT,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK     = SLAVE_MASK_DEFAULT,
  parameter int unsigned                  TIMEOUT_CYCLES = 255
) (
  input logic              clk_i,
  input logic              rstn_i,
  wb_addr_decoder_if.slave bus
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned IDX_W = idx_width(NUM_SLAVES);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
    $error("wb_addr_decoder: NUM_SLAVES must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_addr_decoder: TIMEOUT_CYCLES must be 1..65535");
  end

  wb_dec_state_e state_q, state_d;

  logic                  req_c;
  logic                  hit_c;
  logic [IDX_W-1:0]      hit_idx_c;
  logic [IDX_W-1:0]      tgt_idx_c;
  logic                  sel_stall_c;
  logic                  sel_ack_c;
  logic                  sel_err_c;
  logic [DATA_W-1:0]     sel_rdat_c;
  logic                  timeout_c;

  logic [IDX_W-1:0]      idx_q;
  logic [ADDR_W-1:0]     adr_q;
  logic                  we_q;
  logic [SEL_W-1:0]      sel_q;
  logic [DATA_W-1:0]     wdat_q;

  logic [NUM_SLAVES-1:0] cyc_d, cyc_q;
  logic [NUM_SLAVES-1:0] stb_d, stb_q;
  logic                  ack_d, ack_q;
  logic                  err_d, err_q;
  logic                  stall_d, stall_q;
  logic [DATA_W-1:0]     rdat_d, rdat_q;

  wb_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W)
  ) u_match (
    .adr   (bus.m_adr_i),
    .base  (SLAVE_BASE),
    .mask  (SLAVE_MASK),
    .hit_c (hit_c),
    .idx_c (hit_idx_c)
  );

  assign req_c       = bus.m_cyc_i & bus.m_stb_i;
  assign tgt_idx_c   = (state_q == IDLE) ? hit_idx_c : idx_q;
  assign sel_stall_c = bus.s_stall_i[idx_q];
  assign sel_ack_c   = bus.s_ack_i[idx_q];
  assign sel_err_c   = bus.s_err_i[idx_q];
  assign sel_rdat_c  = bus.s_dat_i[DATA_W*32'(idx_q) +: DATA_W];

`ifdef WB_DECODER_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  // Watchdog restarts with every new slave access
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q == IDLE && state_d == REQ) begin
      tmo_cnt_q <= '0;
    end else if (state_q == REQ || state_q == WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign timeout_c = (state_q == REQ || state_q == WAIT) && (tmo_cnt_q == 16'(TIMEOUT_CYCLES));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Master abort beats everything; a real slave response beats the watchdog
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_c) state_d = hit_c ? REQ : RESP;
      REQ: begin
        if (!bus.m_cyc_i)      state_d = IDLE;
        else if (timeout_c)    state_d = RESP;
        else if (!sel_stall_c) state_d = WAIT;
      end
      WAIT: begin
        if (!bus.m_cyc_i)                                 state_d = IDLE;
        else if (sel_ack_c || sel_err_c || timeout_c)     state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed on the state being entered
  always_comb begin
    cyc_d   = '0;
    stb_d   = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = rdat_q;
    stall_d = (state_d != IDLE);
    case (state_d)
      REQ: begin
        cyc_d = NUM_SLAVES'(1) << tgt_idx_c;
        stb_d = NUM_SLAVES'(1) << tgt_idx_c;
      end
      WAIT: cyc_d = NUM_SLAVES'(1) << idx_q;
      RESP: begin
        if (state_q == WAIT && (sel_ack_c || sel_err_c)) begin
          err_d  = sel_err_c;
          ack_d  = ~sel_err_c;
          rdat_d = (sel_err_c || we_q) ? '0 : sel_rdat_c;
        end else begin
          err_d  = 1'b1;
          rdat_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cyc_q   <= '0;
      stb_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      rdat_q  <= '0;
      idx_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
    end else begin
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      rdat_q  <= rdat_d;
      // Request fields are frozen for the whole slave access
      if (state_q == IDLE && req_c && hit_c) begin
        idx_q  <= hit_idx_c;
        adr_q  <= bus.m_adr_i;
        we_q   <= bus.m_we_i;
        sel_q  <= bus.m_sel_i;
        wdat_q <= bus.m_dat_i;
      end
    end
  end

  assign bus.m_dat_o   = rdat_q;
  assign bus.m_ack_o   = ack_q;
  assign bus.m_err_o   = err_q;
  assign bus.m_stall_o = stall_q;
  assign bus.s_cyc_o   = cyc_q;
  assign bus.s_stb_o   = stb_q;
  assign bus.s_we_o    = we_q;
  assign bus.s_adr_o   = adr_q;
  assign bus.s_dat_o   = wdat_q;
  assign bus.s_sel_o   = sel_q;

endmodule
